// File: rtl/hpdcache_flush_be.sv
// hpdcache_flush_be
//   Writeback flush controller. A victim line is accepted together with its
//   per-access-word dirty mask. Only dirty words are read from the data RAM.
//   Clean words are replaced by zero data with all byte enables low. The line
//   leaves as one write header plus CL_W/MEM_W data flits. Each line holds a
//   directory entry until the memory acknowledges the write. The entry index
//   is used as the memory transaction ID.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   empty_o / full_o             no / all directory entries valid
//   busy_o                       read sequencer not idle
//   err_o                        sticky: ack with out-of-range or unused ID
//   check_nline_i / check_hit_o  pending-write lookup
//   alloc_*                      flush request (valid/ready), line, way, mask
//   data_read_*                  data RAM read port (data one cycle later)
//   ack_o / ack_nline_o          write completion notification
//   mem_req_*                    write header channel (valid/ready)
//   mem_data_*                   write data channel (valid/ready)
//   mem_resp_*                   write acknowledge channel
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Once valid is raised, it stays high and the payload stays stable
// until the transfer. Ready may toggle freely and never depends on valid.
module hpdcache_flush_be #(
    parameter int ENTRIES    = 4,
    parameter int NLINE_W    = 26,
    parameter int SET_W      = 7,
    parameter int WAYS       = 4,
    parameter int CL_W       = 512,
    parameter int ACCESS_W   = 128,
    parameter int MEM_W      = 64,
    parameter int ID_W       = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    output logic                                  empty_o,
    output logic                                  full_o,
    output logic                                  busy_o,
    output logic                                  err_o,
    input  logic [NLINE_W-1:0]                    check_nline_i,
    output logic                                  check_hit_o,
    input  logic                                  alloc_i,
    output logic                                  alloc_ready_o,
    input  logic [NLINE_W-1:0]                    alloc_nline_i,
    input  logic [WAYS-1:0]                       alloc_way_i,
    input  logic [CL_W/ACCESS_W-1:0]              alloc_dirty_i,
    output logic                                  data_read_o,
    output logic [SET_W-1:0]                      data_read_set_o,
    output logic [$clog2(CL_W/ACCESS_W)-1:0]      data_read_word_o,
    output logic [WAYS-1:0]                       data_read_way_o,
    input  logic [ACCESS_W-1:0]                   data_read_data_i,
    output logic                                  ack_o,
    output logic [NLINE_W-1:0]                    ack_nline_o,
    output logic                                  mem_req_valid_o,
    input  logic                                  mem_req_ready_i,
    output logic [NLINE_W+$clog2(CL_W/8)-1:0]     mem_req_addr_o,
    output logic [7:0]                            mem_req_len_o,
    output logic [ID_W-1:0]                       mem_req_id_o,
    output logic                                  mem_data_valid_o,
    input  logic                                  mem_data_ready_i,
    output logic [MEM_W-1:0]                      mem_data_o,
    output logic [MEM_W/8-1:0]                    mem_data_be_o,
    output logic                                  mem_data_last_o,
    input  logic                                  mem_resp_valid_i,
    input  logic [ID_W-1:0]                       mem_resp_id_i,
    output logic                                  mem_resp_ready_o
);

    localparam int AW     = CL_W / ACCESS_W;
    localparam int R      = ACCESS_W / MEM_W;
    localparam int FLITS  = CL_W / MEM_W;
    localparam int WIDX_W = $clog2(AW);
    localparam int OFF_W  = $clog2(CL_W / 8);
    localparam int EIDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int FPTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int RSEL_W = (R > 1) ? $clog2(R) : 1;
    localparam int FLIT_W = (FLITS > 1) ? $clog2(FLITS) : 1;
    localparam int BE_W   = ACCESS_W / 8;
    localparam int MBE_W  = MEM_W / 8;

    typedef enum logic [0:0] {ST_IDLE, ST_SEND} state_t;

    // Read sequencer
    state_t              state_q;
    logic [WIDX_W-1:0]   word_q;
    logic [SET_W-1:0]    set_q;
    logic [WAYS-1:0]     way_q;
    logic [AW-1:0]       dirty_q;
    // One word is in flight between issue and FIFO push. For a dirty word
    // this is the RAM latency. Clean words are delayed the same way, so the
    // FIFO receives at most one push per cycle, in word order.
    logic                pend_q;
    logic                pend_dirty_q;

    // Directory
    logic [ENTRIES-1:0]  dir_valid_q;
    logic [NLINE_W-1:0]  dir_nline_q [ENTRIES];
    logic                err_q;

    // Header FIFO, two entries
    logic [NLINE_W-1:0]  hdr_nline_q [2];
    logic [ID_W-1:0]     hdr_id_q    [2];
    logic                hdr_wr_q;
    logic                hdr_rd_q;
    logic [1:0]          hdr_cnt_q;

    // Data FIFO, ACCESS_W words plus byte enables
    logic [ACCESS_W-1:0] dfifo_data_q [FIFO_DEPTH];
    logic [BE_W-1:0]     dfifo_be_q   [FIFO_DEPTH];
    logic [FPTR_W-1:0]   dfifo_wr_q;
    logic [FPTR_W-1:0]   dfifo_rd_q;
    logic [FCNT_W-1:0]   dfifo_cnt_q;

    // Serializer
    logic [RSEL_W-1:0]   flit_sel_q;
    logic [FLIT_W-1:0]   flit_cnt_q;

    logic                alloc_fire;
    logic                alloc_go;
    logic [EIDX_W-1:0]   free_idx;
    logic                can_issue;
    logic                hdr_pop;
    logic                data_fire;
    logic                dfifo_pop;
    logic                ack_in_range;
    logic [EIDX_W-1:0]   ack_idx;
    logic [ACCESS_W-1:0] head_data;
    logic [BE_W-1:0]     head_be;
    logic [ACCESS_W-1:0] push_data;

    function automatic logic [FPTR_W-1:0] fptr_inc(input logic [FPTR_W-1:0] p);
        if (p == FPTR_W'(FIFO_DEPTH - 1)) return '0;
        return p + 1'b1;
    endfunction

    // Status
    assign full_o           = &dir_valid_q;
    assign empty_o          = ~|dir_valid_q;
    assign busy_o           = (state_q != ST_IDLE);
    assign err_o            = err_q;
    assign mem_resp_ready_o = 1'b1;

    // Reads still owed to the FIFO count as occupied, so a new line is only
    // taken once the previous line has fully left the data path.
    assign alloc_ready_o = (state_q == ST_IDLE) && !full_o && (hdr_cnt_q != 2'd2)
                           && (dfifo_cnt_q == '0) && !pend_q;
    assign alloc_fire    = alloc_i && alloc_ready_o;
    assign alloc_go      = alloc_fire && (|alloc_dirty_i);

    always_comb begin
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!dir_valid_q[i]) free_idx = EIDX_W'(i);
        end
    end

    // Issue a word only if it is sure to find a FIFO slot one cycle later.
    assign can_issue = (state_q == ST_SEND) &&
        (({1'b0, dfifo_cnt_q} + {{FCNT_W{1'b0}}, pend_q}) < (FCNT_W + 1)'(FIFO_DEPTH));

    assign data_read_o      = can_issue && dirty_q[word_q];
    assign data_read_set_o  = set_q;
    assign data_read_word_o = word_q;
    assign data_read_way_o  = way_q;

    assign push_data = pend_dirty_q ? data_read_data_i : '0;

    // Header channel
    assign mem_req_valid_o = (hdr_cnt_q != 2'd0);
    assign mem_req_addr_o  = {hdr_nline_q[hdr_rd_q], {OFF_W{1'b0}}};
    assign mem_req_len_o   = 8'(FLITS - 1);
    assign mem_req_id_o    = hdr_id_q[hdr_rd_q];
    assign hdr_pop         = mem_req_valid_o && mem_req_ready_i;

    // Data channel: FIFO head is cut into R flits, low part first.
    assign head_data        = dfifo_data_q[dfifo_rd_q];
    assign head_be          = dfifo_be_q[dfifo_rd_q];
    assign mem_data_valid_o = (dfifo_cnt_q != '0);
    assign mem_data_last_o  = mem_data_valid_o && (flit_cnt_q == FLIT_W'(FLITS - 1));
    assign data_fire        = mem_data_valid_o && mem_data_ready_i;
    assign dfifo_pop        = data_fire && (flit_sel_q == RSEL_W'(R - 1));

    always_comb begin
        mem_data_o    = '0;
        mem_data_be_o = '0;
        for (int r = 0; r < R; r++) begin
            if (flit_sel_q == RSEL_W'(r)) begin
                mem_data_o    = head_data[r*MEM_W +: MEM_W];
                mem_data_be_o = head_be[r*MBE_W +: MBE_W];
            end
        end
    end

    // Acknowledge: only an in-range ID naming a live entry completes a write.
    assign ack_in_range = (32'(mem_resp_id_i) < 32'(ENTRIES));
    assign ack_idx      = mem_resp_id_i[EIDX_W-1:0];
    assign ack_o        = mem_resp_valid_i && ack_in_range && dir_valid_q[ack_idx];
    assign ack_nline_o  = ack_o ? dir_nline_q[ack_idx] : '0;

    // An entry being acked this cycle no longer shields its line.
    always_comb begin
        check_hit_o = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (dir_valid_q[i] && (dir_nline_q[i] == check_nline_i) &&
                !(ack_o && (ack_idx == EIDX_W'(i))))
                check_hit_o = 1'b1;
        end
    end

    // Read sequencer FSM
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            word_q       <= '0;
            set_q        <= '0;
            way_q        <= '0;
            dirty_q      <= '0;
            pend_q       <= 1'b0;
            pend_dirty_q <= 1'b0;
        end else begin
            pend_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (alloc_go) begin
                        set_q   <= alloc_nline_i[SET_W-1:0];
                        way_q   <= alloc_way_i;
                        dirty_q <= alloc_dirty_i;
                        word_q  <= '0;
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (can_issue) begin
                        pend_q       <= 1'b1;
                        pend_dirty_q <= dirty_q[word_q];
                        word_q       <= word_q + 1'b1;
                        if (word_q == WIDX_W'(AW - 1)) state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Directory and error flag. Alloc picks a free entry and ack frees a
    // valid one, so both can act in the same cycle without conflict.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dir_valid_q <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < ENTRIES; i++) dir_nline_q[i] <= '0;
        end else begin
            if (ack_o) dir_valid_q[ack_idx] <= 1'b0;
            if (alloc_go) begin
                dir_valid_q[free_idx] <= 1'b1;
                dir_nline_q[free_idx] <= alloc_nline_i;
            end
            if (mem_resp_valid_i && !ack_o) err_q <= 1'b1;
        end
    end

    // Header FIFO
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hdr_wr_q  <= 1'b0;
            hdr_rd_q  <= 1'b0;
            hdr_cnt_q <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                hdr_nline_q[i] <= '0;
                hdr_id_q[i]    <= '0;
            end
        end else begin
            if (alloc_go) begin
                hdr_nline_q[hdr_wr_q] <= alloc_nline_i;
                hdr_id_q[hdr_wr_q]    <= ID_W'(free_idx);
                hdr_wr_q              <= ~hdr_wr_q;
            end
            if (hdr_pop) hdr_rd_q <= ~hdr_rd_q;
            hdr_cnt_q <= hdr_cnt_q + {1'b0, alloc_go} - {1'b0, hdr_pop};
        end
    end

    // Data FIFO and serializer
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dfifo_wr_q  <= '0;
            dfifo_rd_q  <= '0;
            dfifo_cnt_q <= '0;
            flit_sel_q  <= '0;
            flit_cnt_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                dfifo_data_q[i] <= '0;
                dfifo_be_q[i]   <= '0;
            end
        end else begin
            if (pend_q) begin
                dfifo_data_q[dfifo_wr_q] <= push_data;
                dfifo_be_q[dfifo_wr_q]   <= {BE_W{pend_dirty_q}};
                dfifo_wr_q               <= fptr_inc(dfifo_wr_q);
            end
            if (data_fire) begin
                flit_sel_q <= dfifo_pop ? '0 : flit_sel_q + 1'b1;
                flit_cnt_q <= (flit_cnt_q == FLIT_W'(FLITS - 1)) ? '0 : flit_cnt_q + 1'b1;
            end
            if (dfifo_pop) dfifo_rd_q <= fptr_inc(dfifo_rd_q);
            dfifo_cnt_q <= dfifo_cnt_q + FCNT_W'(pend_q) - FCNT_W'(dfifo_pop);
        end
    end

endmodule
